// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int CNT_WIDTH   = 16;
  localparam int BURST_WIDTH = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: one-hot grant for the first set req bit after pointer.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(pointer) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter feeding a single FIFO write port.
// Optional per-requester grant counters: define FIFO_WR_ARBITER_CNT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  input  logic                          FULL,
`ifdef FIFO_WR_ARBITER_CNT_EN
  input  logic                          CNT_CLR,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  WR_CNT,
`endif
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(MAX_BURST);

  arb_state_t             state_reg, state_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [BURST_WIDTH-1:0] burst_reg, burst_next, burst_inc;
  logic [NUM_REQ-1:0]     pick;
  logic [IDX_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   ready;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req    (REQ),
    .pointer(ptr_reg),
    .gnt    (pick)
  );

  assign ready     = !W_INC || !FULL;
  assign burst_inc = burst_reg + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      burst_reg <= '0;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      burst_reg <= burst_next;
      ptr_reg   <= ptr_next;
    end
  end

  // With MAX_BURST=1 an IDLE grant completes its burst at once, so LOCK is skipped.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    burst_next = burst_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|GNT) begin
          owner_next = gnt_idx;
          burst_next = BURST_WIDTH'(1);
          if (MAX_BURST == 1) ptr_next = gnt_idx;
          else                state_next = LOCK;
        end
      end
      LOCK: begin
        if (ready) begin
          if (!REQ[owner_reg]) begin
            state_next = IDLE;
            ptr_next   = owner_reg;
          end else begin
            burst_next = burst_inc;
            if (burst_inc == BURST_MAX) begin
              state_next = IDLE;
              ptr_next   = owner_reg;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    GNT = '0;
    if (RST && ready) begin
      if (state_reg == IDLE)  GNT = pick;
      else if (REQ[owner_reg]) GNT[owner_reg] = 1'b1;
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) gnt_idx = IDX_W'(i);
    end
    sel_data = REQ_DATA[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Output stage: a held beat is replaced by a new grant or retired when consumed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      W_INC   <= 1'b0;
      WR_DATA <= '0;
    end else if (|GNT) begin
      W_INC   <= 1'b1;
      WR_DATA <= sel_data;
    end else if (!FULL) begin
      W_INC   <= 1'b0;
    end
  end

`ifdef FIFO_WR_ARBITER_CNT_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                          cnt_reg <= '0;
        else if (CNT_CLR)                  cnt_reg <= '0;
        else if (GNT[gi] && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
      end
      assign WR_CNT[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (MAX_BURST=4 and MAX_BURST=1 instances).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req2;
  logic [31:0] req_data, req_data2;
  logic        full, full2;
  logic [3:0]  gnt, gnt2;
  logic        w_inc, w_inc2;
  logic [7:0]  wr_data, wr_data2;
`ifdef FIFO_WR_ARBITER_CNT_EN
  logic        cnt_clr, cnt_clr2;
  logic [63:0] wr_cnt, wr_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .CLK(clk), .RST(rst_n), .REQ(req), .REQ_DATA(req_data), .GNT(gnt), .FULL(full),
`ifdef FIFO_WR_ARBITER_CNT_EN
    .CNT_CLR(cnt_clr), .WR_CNT(wr_cnt),
`endif
    .W_INC(w_inc), .WR_DATA(wr_data)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) dut_rr (
    .CLK(clk), .RST(rst_n), .REQ(req2), .REQ_DATA(req_data2), .GNT(gnt2), .FULL(full2),
`ifdef FIFO_WR_ARBITER_CNT_EN
    .CNT_CLR(cnt_clr2), .WR_CNT(wr_cnt2),
`endif
    .W_INC(w_inc2), .WR_DATA(wr_data2)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] d, logic f,
                              logic [3:0] g, logic w, logic [7:0] wd);
    vec_t v;
    v.req = r; v.data = d; v.full = f; v.gnt = g; v.winc = w; v.wdata = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [31:0] RDAT = 32'h3C2C1C0C;

  int consumed;
  logic [15:0] cnt_slice;

  initial begin
    // single requester, 4-beat burst with per-grant data
    tbl[0]  = mk(4'b0001, 32'hD0, 1'b0, 4'b0001, 1'b0, 8'h00);
    tbl[1]  = mk(4'b0001, 32'hD1, 1'b0, 4'b0001, 1'b1, 8'hD0);
    tbl[2]  = mk(4'b0001, 32'hD2, 1'b0, 4'b0001, 1'b1, 8'hD1);
    tbl[3]  = mk(4'b0001, 32'hD3, 1'b0, 4'b0001, 1'b1, 8'hD2);
    tbl[4]  = mk(4'b0000, 32'h00, 1'b0, 4'b0000, 1'b1, 8'hD3);
    tbl[5]  = mk(4'b0000, 32'h00, 1'b0, 4'b0000, 1'b0, 8'hD3);
    // all requesting: 4-beat bursts rotating 1,2,3,0 (pointer now 0)
    tbl[6]  = mk(4'b1111, RDAT, 1'b0, 4'b0010, 1'b0, 8'hD3);
    tbl[7]  = mk(4'b1111, RDAT, 1'b0, 4'b0010, 1'b1, 8'h1C);
    tbl[8]  = mk(4'b1111, RDAT, 1'b0, 4'b0010, 1'b1, 8'h1C);
    tbl[9]  = mk(4'b1111, RDAT, 1'b0, 4'b0010, 1'b1, 8'h1C);
    tbl[10] = mk(4'b1111, RDAT, 1'b0, 4'b0100, 1'b1, 8'h1C);
    tbl[11] = mk(4'b1111, RDAT, 1'b0, 4'b0100, 1'b1, 8'h2C);
    tbl[12] = mk(4'b1111, RDAT, 1'b0, 4'b0100, 1'b1, 8'h2C);
    tbl[13] = mk(4'b1111, RDAT, 1'b0, 4'b0100, 1'b1, 8'h2C);
    tbl[14] = mk(4'b1111, RDAT, 1'b0, 4'b1000, 1'b1, 8'h2C);
    tbl[15] = mk(4'b1111, RDAT, 1'b0, 4'b1000, 1'b1, 8'h3C);
    tbl[16] = mk(4'b1111, RDAT, 1'b0, 4'b1000, 1'b1, 8'h3C);
    tbl[17] = mk(4'b1111, RDAT, 1'b0, 4'b1000, 1'b1, 8'h3C);
    tbl[18] = mk(4'b1111, RDAT, 1'b0, 4'b0001, 1'b1, 8'h3C);
    tbl[19] = mk(4'b1111, RDAT, 1'b0, 4'b0001, 1'b1, 8'h0C);
    // owner drops its request: release without a grant
    tbl[20] = mk(4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 8'h0C);
    tbl[21] = mk(4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h0C);

    rst_n = 1'b0; req = 4'b1111; req_data = '0; full = 1'b0;
    req2 = '0; req_data2 = '0; full2 = 1'b0;
`ifdef FIFO_WR_ARBITER_CNT_EN
    cnt_clr = 1'b0; cnt_clr2 = 1'b0;
`endif
    #2;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_winc", 32'(w_inc), 32'h0);
    check("reset_wdata", 32'(wr_data), 32'h0);
    @(negedge clk); req = '0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      req = tbl[i].req; req_data = tbl[i].data; full = tbl[i].full;
      #1;
      $display("row %0d req=%b full=%b gnt=%b w_inc=%b wr_data=%h", i, req, full, gnt, w_inc, wr_data);
      check($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("row%0d_winc", i), 32'(w_inc), 32'(tbl[i].winc));
      check($sformatf("row%0d_wdata", i), 32'(wr_data), 32'(tbl[i].wdata));
    end

    // FULL stall holds the beat; it is consumed exactly once
    consumed = 0;
    @(negedge clk); req = 4'b0100; req_data = 32'h00D50000; full = 1'b0; #1;
    check("stall_first_gnt", 32'(gnt), 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req = 4'b0100; req_data = 32'h00D60000; full = 1'b1; #1;
      $display("stall %0d gnt=%b w_inc=%b wr_data=%h", k, gnt, w_inc, wr_data);
      check("stall_gnt", 32'(gnt), 32'h0);
      check("stall_winc", 32'(w_inc), 32'h1);
      check("stall_wdata", 32'(wr_data), 32'hD5);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req = 4'b0000; full = 1'b0; #1;
      if (w_inc && wr_data == 8'hD5) consumed++;
    end
    check("stall_consumed_once", 32'(consumed), 32'h1);

    // reset mid-LOCK drops the beat and restores requester-0-first priority
    @(negedge clk); req = 4'b1010; req_data = 32'h11002200; #1;
    check("pre_rst_gnt", 32'(gnt), 32'h8);
    @(negedge clk); #1;
    check("lock_winc", 32'(w_inc), 32'h1);
    #1 rst_n = 1'b0; #1;
    $display("reset mid-lock gnt=%b w_inc=%b wr_data=%h", gnt, w_inc, wr_data);
    check("rst_async_winc", 32'(w_inc), 32'h0);
    check("rst_async_wdata", 32'(wr_data), 32'h0);
    check("rst_gnt_forced", 32'(gnt), 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_gnt", 32'(gnt), 32'h2);
    @(negedge clk); req = '0; #1;
    check("post_rst_wdata", 32'(wr_data), 32'h22);

    // MAX_BURST=1: pure round-robin between requesters 0 and 2
    @(negedge clk); req2 = 4'b0101; req_data2 = 32'h00330011; #1;
    check("rr_gnt0", 32'(gnt2), 32'h1);
    @(negedge clk); #1;
    check("rr_gnt1", 32'(gnt2), 32'h4);
    check("rr_wdata1", 32'(wr_data2), 32'h11);
    @(negedge clk); #1;
    check("rr_gnt2", 32'(gnt2), 32'h1);
    check("rr_wdata2", 32'(wr_data2), 32'h33);
    @(negedge clk); #1;
    check("rr_gnt3", 32'(gnt2), 32'h4);
    @(negedge clk); req2 = '0;

`ifdef FIFO_WR_ARBITER_CNT_EN
    @(negedge clk); req = '0; cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0; req = 4'b0100; req_data = 32'h00770000;
    for (int k = 0; k < 10; k++) @(negedge clk);
    req = '0; #1;
    cnt_slice = wr_cnt[47:32];
    $display("counter after 10 grants = %0d", cnt_slice);
    check("cnt_after_10", 32'(cnt_slice), 32'd10);
    @(negedge clk); req = 4'b0100; cnt_clr = 1'b1; #1;
    check("cnt_clr_gnt", 32'(gnt), 32'h4);
    @(negedge clk); cnt_clr = 1'b0; req = '0; #1;
    cnt_slice = wr_cnt[47:32];
    check("cnt_clr_wins", 32'(cnt_slice), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
